// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FIFO entry layout, FSM states, constants.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

    // Size of one instruction word in bytes; the PC steps by this amount.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Occupancy counter width; holds 0..16 so it covers every legal buffer depth.
    localparam int CNT_W = 5;

    // One buffered fetch result. A faulting fetch carries instr = 0 and fault = 1.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    // GAP : bus idle for one cycle, clears the slave's registered ack.
    // REQ : strobe held on the current PC until ack or err.
    // HALT: parked after a bus error until the next redirect.
    typedef enum logic [1:0] {
        GAP  = 2'd0,
        REQ  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/wb_bus.sv
// Instruction-side Wishbone subset: address/strobe out, ack/err/read data back.
// Latency: n/a (wires only).
// Backpressure: the master holds addr/stb stable until the slave answers with ack or err.
interface wb_bus;

    logic [31:0] addr;
    logic        stb;
    logic        we;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output addr,
        output stb,
        output we,
        input  ack,
        input  err,
        input  rdata
    );

    modport slave (
        input  addr,
        input  stb,
        input  we,
        output ack,
        output err,
        output rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer of fetch entries; head is read straight from storage (no output register).
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: push is dropped when full without a pop; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               push,
    input  fetch_entry_t       push_dat,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    localparam int              AW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(Depth);

    fetch_entry_t       r_mem [Depth];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    // Pop only real entries; a push into a full buffer is legal only alongside a pop.
    always_comb begin
        w_do_pop  = pop & (r_count != '0);
        w_do_push = push & ((r_count != FULL) | w_do_pop);
    end

    // Pointer, occupancy and storage update; flush empties the buffer and ignores push/pop.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Wishbone instruction fetcher: sequential PC, redirect flush, bus errors become fault entries.
// Latency: 3 cycles per word (GAP, REQ, REQ+ack); first word visible 3 cycles after reset release.
// Backpressure: a request is issued only with a free buffer slot; decode pops with valid/ready.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] ResetPc   = 32'h0000_0000,
    parameter int          FifoDepth = 4
) (
    input  logic         clk_in,
    input  logic         reset_in,
    wb_bus.master        bus_master,
    input  logic         redirect_valid_in,
    input  logic [31:0]  redirect_pc_in,
    output logic         instr_valid_out,
    input  logic         instr_ready_in,
    output logic [31:0]  instr_out,
    output logic [31:0]  instr_pc_out,
    output logic         instr_fault_out
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(FifoDepth);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [31:0]         r_pc;
    logic [31:0]         w_pc_nxt;
    logic                w_stb;
    logic                w_push;
    fetch_entry_t        w_push_dat;
    logic                w_flush;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count;
    fetch_entry_t        w_head;

    // State and PC registers; reset parks in GAP so the first cycle never strobes.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= GAP;
            r_pc    <= ResetPc;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state, PC and buffer push; a redirect overrides whatever the bus returned this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stb       = 1'b0;
        w_push      = 1'b0;
        w_push_dat  = '0;
        w_flush     = 1'b0;

        case (r_state)
            GAP: begin
                // Space is reserved here: only one request is ever outstanding.
                if (w_count < FULL) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_stb = 1'b1;
                if (bus_master.ack) begin
                    w_push           = 1'b1;
                    w_push_dat.pc    = r_pc;
                    w_push_dat.instr = bus_master.rdata;
                    w_push_dat.fault = 1'b0;
                    w_pc_nxt         = r_pc + INSTR_BYTES;
                    w_state_nxt      = GAP;
                end else if (bus_master.err) begin
                    // Faulting PC is kept so the entry and a later refetch agree.
                    w_push           = 1'b1;
                    w_push_dat.pc    = r_pc;
                    w_push_dat.instr = 32'h0;
                    w_push_dat.fault = 1'b1;
                    w_state_nxt      = HALT;
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = GAP;
            end
        endcase

        if (redirect_valid_in) begin
            w_flush     = 1'b1;
            w_push      = 1'b0;
            w_pc_nxt    = redirect_pc_in;
            w_state_nxt = GAP;
        end
    end

    // Decode handshake: the head leaves when it is valid and accepted.
    always_comb begin
        w_pop = instr_valid_out & instr_ready_in;
    end

    fetch_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .push     (w_push),
        .push_dat (w_push_dat),
        .pop      (w_pop),
        .flush    (w_flush),
        .count    (w_count),
        .head     (w_head)
    );

    assign bus_master.addr = r_pc;
    assign bus_master.stb  = w_stb;
    assign bus_master.we   = 1'b0;

    assign instr_valid_out = (w_count != '0);
    assign instr_out       = w_head.instr;
    assign instr_pc_out    = w_head.pc;
    assign instr_fault_out = w_head.fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: fixed-timing program memory model plus output scoreboard.
// Latency: n/a.
// Backpressure: decode ready is raised only around the single edge that pops an observed head.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic        clk_in;
    logic        reset_in;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_fault_out;

    int checks = 0;
    int errors = 0;

    fetch_entry_t sb[$];

    wb_bus bus ();

    instruction_fetch_unit #(
        .ResetPc   (32'h0000_0000),
        .FifoDepth (4)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .bus_master        (bus),
        .redirect_valid_in (redirect_valid_in),
        .redirect_pc_in    (redirect_pc_in),
        .instr_valid_out   (instr_valid_out),
        .instr_ready_in    (instr_ready_in),
        .instr_out         (instr_out),
        .instr_pc_out      (instr_pc_out),
        .instr_fault_out   (instr_fault_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Program memory contents: word at byte address a.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h13 + (a << 5);
    endfunction

    function automatic fetch_entry_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic f);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = ins;
        e.fault = f;
        return e;
    endfunction

    // Slave: registered ack/rdata one cycle after stb, ack gated by stb, combinational err.
    logic        r_s_ack;
    logic [31:0] r_s_rdata;
    logic        w_s_err;
    assign w_s_err   = bus.stb & (bus.we | (bus.addr[1:0] != 2'b00));
    assign bus.err   = w_s_err;
    assign bus.ack   = r_s_ack & bus.stb;
    assign bus.rdata = r_s_rdata;

    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_s_ack   <= 1'b0;
            r_s_rdata <= 32'h0;
        end else begin
            r_s_ack   <= bus.stb & ~w_s_err;
            r_s_rdata <= word_at(bus.addr);
        end
    end

    // Waits (bounded) for a valid head at a falling edge, captures it, pops it on the next edge.
    task automatic pop_one(output fetch_entry_t got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk_in);
            if (instr_valid_out) begin
                got.pc         = instr_pc_out;
                got.instr      = instr_out;
                got.fault      = instr_fault_out;
                ok             = 1'b1;
                instr_ready_in = 1'b1;
                @(posedge clk_in);
                #1 instr_ready_in = 1'b0;
            end
        end
    endtask

    // Pulls one head entry and compares it against the scoreboard front.
    task automatic expect_pop(input string name);
        fetch_entry_t got;
        fetch_entry_t exp;
        bit           ok;
        pop_one(got, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no valid output within budget", name);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected entry pc=%h instr=%h fault=%0b", name, got.pc, got.instr, got.fault);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got pc=%h instr=%h fault=%0b expected pc=%h instr=%h fault=%0b",
                         name, got.pc, got.instr, got.fault, exp.pc, exp.instr, exp.fault);
            end
        end
    endtask

    // Synchronous-looking reset pulse released on a falling edge; returns at that edge.
    task automatic apply_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        sb.delete();
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk_in);
        redirect_valid_in = 1'b1;
        redirect_pc_in    = pc;
        @(negedge clk_in);
        redirect_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [69:0] got;
        logic [69:0] exp;
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        got = {bus.stb, bus.addr, instr_valid_out, instr_out, instr_fault_out, bus.we, 2'b00};
        exp = {1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, exp);
        end
        checks++;
        if (instr_pc_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc_out: got %h expected 0", instr_pc_out);
        end
        reset_in = 1'b0;
    endtask

    // From release: stb 0,1,1 repeating; address i/3*4 while strobing.
    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(32'(k * 4), word_at(32'(k * 4)), 1'b0));
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (bus.stb !== ((i % 3) != 0)) begin
                errors++;
                $display("FAIL stb_pattern cycle %0d: got %b expected %b", i, bus.stb, ((i % 3) != 0));
            end
            if ((i % 3) == 1) begin
                checks++;
                if (bus.addr !== 32'(i / 3 * 4)) begin
                    errors++;
                    $display("FAIL addr_seq cycle %0d: got %h expected %h", i, bus.addr, 32'(i / 3 * 4));
                end
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({bus.stb, instr_valid_out} !== 2'b01) begin
                errors++;
                $display("FAIL full_idle cycle %0d: got stb=%b valid=%b expected stb=0 valid=1",
                         i, bus.stb, instr_valid_out);
            end
            @(negedge clk_in);
        end
        expect_pop("drain0");
        expect_pop("drain1");
        expect_pop("drain2");
        expect_pop("drain3");
        sb.push_back(mk(32'h10, word_at(32'h10), 1'b0));
        expect_pop("after_drain");
    endtask

    task automatic test_redirect_flush();
        apply_reset();
        repeat (8) @(negedge clk_in);
        checks++;
        if (bus.stb !== 1'b1 || bus.ack !== 1'b1 || bus.addr !== 32'h8) begin
            errors++;
            $display("FAIL pre_redirect: got stb=%b ack=%b addr=%h expected 1 1 00000008",
                     bus.stb, bus.ack, bus.addr);
        end
        redirect_valid_in = 1'b1;
        redirect_pc_in    = 32'h100;
        @(negedge clk_in);
        redirect_valid_in = 1'b0;
        checks++;
        if (bus.stb !== 1'b0 || instr_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL redirect_gap: got stb=%b valid=%b expected 0 0", bus.stb, instr_valid_out);
        end
        @(negedge clk_in);
        checks++;
        if (bus.stb !== 1'b1 || bus.addr !== 32'h100) begin
            errors++;
            $display("FAIL redirect_req: got stb=%b addr=%h expected 1 00000100", bus.stb, bus.addr);
        end
        sb.push_back(mk(32'h100, word_at(32'h100), 1'b0));
        sb.push_back(mk(32'h104, word_at(32'h104), 1'b0));
        expect_pop("redir0");
        expect_pop("redir1");
    endtask

    task automatic test_misaligned_fault();
        do_redirect(32'h102);
        sb.push_back(mk(32'h102, 32'h0, 1'b1));
        expect_pop("fault_entry");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            checks++;
            if (bus.stb !== 1'b0 || instr_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL halt_idle cycle %0d: got stb=%b valid=%b expected 0 0",
                         i, bus.stb, instr_valid_out);
            end
        end
        do_redirect(32'h200);
        sb.push_back(mk(32'h200, word_at(32'h200), 1'b0));
        sb.push_back(mk(32'h204, word_at(32'h204), 1'b0));
        expect_pop("resume0");
        expect_pop("resume1");
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (10) @(negedge clk_in);
        checks++;
        if (bus.stb !== 1'b1 || bus.addr !== 32'hC) begin
            errors++;
            $display("FAIL pre_reset_req: got stb=%b addr=%h expected 1 0000000c", bus.stb, bus.addr);
        end
        #2 reset_in = 1'b1;
        #1;
        checks++;
        if (bus.stb !== 1'b0 || instr_valid_out !== 1'b0 || bus.addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got stb=%b valid=%b addr=%h expected 0 0 00000000",
                     bus.stb, instr_valid_out, bus.addr);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        sb.delete();
        sb.push_back(mk(32'h0, word_at(32'h0), 1'b0));
        expect_pop("restart0");
    endtask

    task automatic test_pc_wrap();
        do_redirect(32'hFFFF_FFF8);
        sb.push_back(mk(32'hFFFF_FFF8, word_at(32'hFFFF_FFF8), 1'b0));
        sb.push_back(mk(32'hFFFF_FFFC, word_at(32'hFFFF_FFFC), 1'b0));
        sb.push_back(mk(32'h0000_0000, word_at(32'h0000_0000), 1'b0));
        expect_pop("wrap0");
        expect_pop("wrap1");
        expect_pop("wrap2");
    endtask

    initial begin
        reset_in          = 1'b1;
        redirect_valid_in = 1'b0;
        redirect_pc_in    = 32'h0;
        instr_ready_in    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_misaligned_fault();
        test_async_reset();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
